lfsr_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the 4-line request interface of the circuit under test (CUT).
- On start, takes over the request1..request4 lines, drives them with a maximal-length 4-bit LFSR sequence for a programmable number of patterns, and compacts the CUT's 4-bit response in a MISR.
- Compares the final signature against a golden value and reports pass/fail.
- Sits between the functional requesters and the CUT; test_mode selects the request mux.

---
 rtl/lfsr_bist_ctrl.sv | 143 ++++++++++++++
 tb/tb_lfsr_bist_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bist_ctrl.sv
// lfsr_bist_ctrl: BIST sequencer for the 4-line request interface of the CUT.
// On start it drives request1..4 from a maximal-length 4-bit LFSR for
// NUM_PATTERNS cycles, compacts the CUT response in a 4-bit MISR, then
// compares the final signature with GOLDEN.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        begin a run (sampled only in IDLE or DONE)
//   abort_i        synchronous abort, returns to IDLE (priority over start)
//   resp_i         CUT response, one registered cycle behind the requests
//   test_mode_o    high while the controller owns request1..4
//   test_request_o pattern for request4..request1 (bit0 = request1)
//   busy_o         high in RUN or SETTLE
//   done_o         high in DONE
//   pass_o         valid while done: signature equals GOLDEN
//   signature_o    current MISR contents

module lfsr_bist_ctrl #(
    parameter logic [3:0]  SEED         = 4'b0001,
    parameter int unsigned NUM_PATTERNS = 15,
    parameter logic [3:0]  GOLDEN       = 4'b0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [3:0] resp_i,
    output logic       test_mode_o,
    output logic [3:0] test_request_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] signature_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // An all-zero LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [3:0]  SEED_EFF = (SEED == 4'b0000) ? 4'b0001 : SEED;
    localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS - 1);

    state_t      state_q;
    logic [3:0]  lfsr_q;
    logic [3:0]  lfsr_d;
    logic [3:0]  misr_q;
    logic [3:0]  misr_d;
    logic [15:0] cnt_q;
    logic [3:0]  treq_q;
    logic        tmode_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        last_pat;

    // x^4 + x^3 + 1, period 15
    assign lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign misr_d   = {misr_q[2:0], misr_q[3] ^ misr_q[2]} ^ resp_i;
    assign last_pat = (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= 4'b0000;
            misr_q  <= 4'b0000;
            cnt_q   <= 16'd0;
            treq_q  <= 4'b0000;
            tmode_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= 4'b0000;
            misr_q  <= 4'b0000;
            cnt_q   <= 16'd0;
            treq_q  <= 4'b0000;
            tmode_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        lfsr_q  <= SEED_EFF;
                        misr_q  <= 4'b0000;
                        cnt_q   <= 16'd0;
                        treq_q  <= SEED_EFF;
                        tmode_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    lfsr_q <= lfsr_d;
                    cnt_q  <= cnt_q + 16'd1;
                    // resp in RUN cycle 0 is not a response to any pattern
                    if (cnt_q != 16'd0) begin
                        misr_q <= misr_d;
                    end
                    if (last_pat) begin
                        state_q <= S_SETTLE;
                        treq_q  <= 4'b0000;
                    end else begin
                        treq_q  <= lfsr_d;
                    end
                end
                S_SETTLE: begin
                    // captures the response to the last pattern
                    misr_q  <= misr_d;
                    state_q <= S_CHECK;
                    tmode_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                S_CHECK: begin
                    pass_q  <= (misr_q == GOLDEN);
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign test_mode_o    = tmode_q;
    assign test_request_o = treq_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign signature_o    = misr_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// tb_lfsr_bist_ctrl: directed bench for lfsr_bist_ctrl over several
// parameter sets, with a queue of expected request patterns.

module tb_lfsr_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] st = '0;
    logic [5:0] ab = '0;

    logic [5:0]      tm;
    logic [5:0][3:0] treq;
    logic [5:0]      bz;
    logic [5:0]      dn;
    logic [5:0]      ps;
    logic [5:0][3:0] sig;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb [$];

    localparam logic [3:0] SEQ [15] = '{
        4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
        4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8
    };

    always #5 clk = ~clk;

    // 0: N=15  1: N=2 registered-copy CUT  2: same, GOLDEN=0101
    // 3: N=1 registered-copy CUT  4: N=20  5: SEED=0, N=3
    for (genvar g = 0; g < 6; g++) begin : g_dut
        logic [3:0] cut_resp;
        always_ff @(posedge clk)
            cut_resp <= (g >= 1 && g <= 3) ? treq[g] : 4'b0000;
        lfsr_bist_ctrl #(
            .SEED         (g == 5 ? 4'b0000 : 4'b0001),
            .NUM_PATTERNS (g == 0 ? 15 : g == 3 ? 1 :
                           g == 4 ? 20 : g == 5 ? 3 : 2),
            .GOLDEN       (g == 2 ? 4'b0101 : 4'b0000)
        ) dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .start_i        (st[g]),
            .abort_i        (ab[g]),
            .resp_i         (cut_resp),
            .test_mode_o    (tm[g]),
            .test_request_o (treq[g]),
            .busy_o         (bz[g]),
            .done_o         (dn[g]),
            .pass_o         (ps[g]),
            .signature_o    (sig[g])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(int g, int n, logic [3:0] settle_sig,
                       logic [3:0] fin_sig, logic fin_pass);
        int edges;
        int busy_cnt;
        logic [3:0] e;
        for (int k = 0; k < n; k++) sb.push_back(SEQ[k % 15]);
        @(negedge clk);
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
        edges = 1;
        busy_cnt = 0;
        while (!dn[g] && edges < 100) begin
            if (bz[g]) begin
                busy_cnt++;
                if (busy_cnt == 1) chk("sig_cleared", sig[g], 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("pattern", treq[g], e);
                    chk("tmode_run", tm[g], 1);
                end else begin
                    chk("settle_req", treq[g], 0);
                    chk("settle_tmode", tm[g], 1);
                    chk("settle_sig", sig[g], settle_sig);
                end
            end else begin
                chk("check_req", treq[g], 0);
                chk("check_tmode", tm[g], 0);
            end
            @(negedge clk);
            edges++;
        end
        chk("done_latency", edges, n + 3);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
        chk("busy_cycles", busy_cnt, n + 1);
        chk("done", dn[g], 1);
        chk("signature", sig[g], fin_sig);
        chk("pass", ps[g], fin_pass);
        chk("done_tmode", tm[g], 0);
        chk("done_busy", bz[g], 0);
        chk("done_req", treq[g], 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tmode", tm, 0);
        chk("rst_req", treq, 0);
        chk("rst_busy", bz, 0);
        chk("rst_done", dn, 0);
        chk("rst_pass", ps, 0);
        chk("rst_sig", sig, 0);
        rst = 1'b0;

        run(0, 15, 4'h0, 4'h0, 1'b1);

        // reset while pattern 5 is on the lines
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_pattern", treq[0], 4'd6);
        chk("pre_rst_tmode", tm[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tmode", tm[0], 0);
        chk("async_rst_req", treq[0], 0);
        chk("async_rst_busy", bz[0], 0);
        chk("async_rst_done", dn[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", bz[0], 0);
        run(0, 15, 4'h0, 4'h0, 1'b1);

        run(1, 2, 4'h1, 4'h0, 1'b1);
        @(negedge clk);
        ab[1] = 1'b1;
        @(negedge clk);
        ab[1] = 1'b0;
        chk("abort_done_clr", dn[1], 0);
        chk("abort_pass_clr", ps[1], 0);

        run(2, 2, 4'h1, 4'h0, 1'b0);
        run(3, 1, 4'h0, 4'h1, 1'b0);
        run(3, 1, 4'h0, 4'h1, 1'b0);
        run(4, 20, 4'h0, 4'h0, 1'b1);
        run(4, 20, 4'h0, 4'h0, 1'b1);
        run(5, 3, 4'h0, 4'h0, 1'b1);

        // start during RUN is ignored; abort at pattern 3
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        chk("ab_p0", treq[0], 4'd1);
        @(negedge clk);
        chk("ab_p1", treq[0], 4'd2);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        chk("ab_p2", treq[0], 4'd4);
        @(negedge clk);
        chk("ab_p3", treq[0], 4'd9);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("ab_tmode", tm[0], 0);
        chk("ab_done", dn[0], 0);
        chk("ab_sig", sig[0], 0);
        chk("ab_busy", bz[0], 0);
        chk("ab_req", treq[0], 0);
        @(negedge clk);
        chk("ab_idle_busy", bz[0], 0);
        chk("ab_idle_done", dn[0], 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
